// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Optional hold-time limit is enabled by defining ARB_TIMEOUT_EN.
package rr_arb8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StGap
    } arb_state_e;

    // Rotate right by s: result bit j is v[(j + s) mod N_REQ].
    function automatic logic [N_REQ-1:0] rot_right(input logic [N_REQ-1:0] v,
                                                   input logic [IDX_W-1:0] s);
        logic [2*N_REQ-1:0] w_dbl;
        w_dbl = {v, v};
        return w_dbl[{1'b0, s} +: N_REQ];
    endfunction

endpackage

// File: rtl/rr_arb8_prio_enc8.sv
// Combinational 8-to-3 priority encoder; the highest asserted index wins.
module prio_enc8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for eight requesters with registered one-hot grant and index.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid,
    output logic             o_timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb8: MAX_HOLD must be within 2..255");
    end

    arb_state_e       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic [IDX_W-1:0] r_last;

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_valid;
    logic [IDX_W-1:0] w_win;

    // Rotating so that req[last-1] lands on the top bit turns fixed priority into round-robin.
    assign w_rot = rot_right(i_req, r_last);

    prio_enc8 u_enc (
        .i_req   (w_rot),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    assign w_win = w_enc_idx + r_last;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_last      <= '0;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (i_en && w_enc_valid) begin
                        r_gnt       <= N_REQ'(1) << w_win;
                        r_gnt_idx   <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_last      <= w_win;
                        r_state     <= StBusy;
`ifdef ARB_TIMEOUT_EN
                        r_hold_cnt  <= '0;
`endif
                    end
                end
                StBusy: begin
                    if (!i_en || !i_req[r_gnt_idx]) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= StGap;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_hold_cnt == HoldLast) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= StGap;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
`endif
                end
                StGap: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
    assign o_timeout   = r_timeout;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Round-robin arbiter sharing one resource among eight requesters. It wraps an 8-to-3 priority encoder behind a rotating priority mask, so the descending-index priority becomes fair, lockable grants. The arbiter sits between the requesters and the shared resource. It issues a registered one-hot grant and a binary index that the resource mux consumes directly.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held (used only with ARB_TIMEOUT_EN); legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low forces release and blocks new grants.
- req  input  8  request vector, bit i = requester i; held high for the whole transaction.
- gnt  output  8  registered one-hot grant; all zero when no grant.
- gnt_idx  output  3  binary index of granted requester; holds the last value when gnt_valid=0.
- gnt_valid  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- State machine: IDLE, BUSY, GAP.
- IDLE, en=1, req≠0:
  - Pick the winner with the rotating search, load gnt/gnt_idx, set gnt_valid, go to BUSY.
  - Update last = winner.
- IDLE, en=0 or req=0: stay in IDLE, outputs zero.
- Rotating search from pointer last: order is last-1, last-2, …, 0, 7, 6, …, last (wrap 0→7). The first asserted req in this order wins.
- BUSY: hold the grant while req[gnt_idx]=1 and en=1.
  - On req[gnt_idx]=0 or en=0: clear gnt and gnt_valid, go to GAP.
- GAP: exactly one cycle with no grant, then IDLE. This guarantees a one-cycle bus turnaround between owners.
- Requests from other requesters during BUSY/GAP are ignored; they are evaluated in IDLE.
- Simultaneous requests in IDLE: only the rotating order decides.
- Reset mid-transaction:
  - gnt, gnt_idx, gnt_valid and timeout all go to 0.
  - State goes to IDLE, last goes to 0.
  - The next search order is 7..0, identical to the plain fixed-priority encoder.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, last=3'd0, hold counter=0.

## Timing
- req→gnt latency: 1 clock. req is sampled at edge N in IDLE; gnt is valid after edge N.
- Release: the requester drops req before edge N. gnt falls after edge N, GAP covers cycle N+1, and the earliest next grant appears after edge N+2.
- Back-to-back requester minimum period: request-to-request spacing is grant length + 2 cycles.
- en low in BUSY: gnt clears after the next edge. en has no effect on the pointer.
- All outputs are registered; no combinational path from req to gnt.

## Configuration
- ARB_TIMEOUT_EN defined:
  - 8-bit hold counter, reset to 0 on each grant, increments each BUSY cycle.
  - When the count reaches MAX_HOLD-1 while still in BUSY: grant revoked, timeout pulses for one cycle with gnt falling, state goes to GAP.
  - A requester still asserting req competes again at the lowest priority, because last = its index.
- ARB_TIMEOUT_EN undefined: no counter, grant held indefinitely, timeout tied to 0, MAX_HOLD ignored.

## Structure
- Shared package rr_arb8_pkg: state enum (IDLE, BUSY, GAP), constant N_REQ=8, IDX_W=3.
- Sub-module prio_enc8: combinational 8→3 descending-priority encoder with valid output.
  - The arbiter rotates req right by last, encodes, then adds the offset modulo 8 to recover the true index.
- Top holds the FSM, the pointer, the optional hold counter and the output registers.

## Test plan
- Reset, en=1, req=8'hFF held:
  - Grants in order 7,6,5,…,0,7; each grant lasts until that req bit drops, with a GAP cycle between grants.
- After grant to 4, req=8'b0011_0000:
  - Grant to 5 only after 4 has been granted.
  - After 5 releases with req=8'b0011_0000 still pending, next grant is 4 (wrap order 4,3,…).
- Single req[2] pulse held 3 cycles:
  - gnt=8'h04 and gnt_idx=2 one cycle after assertion.
  - gnt drops one cycle after req[2] drops.
  - gnt_valid stays 0 during GAP.
- en=0 while gnt=8'h08 with req[3] still high:
  - gnt=0 next cycle.
  - With en=0 and req=8'hFF: no grant.
  - en=1 restores grants starting at index 2.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req[6] held forever with req[1] high:
  - gnt[6] lasts 4 cycles, timeout pulses once, GAP, then gnt[1] is granted.
- Async rst_n asserted mid-BUSY (gnt=8'h20):
  - Outputs zero immediately, without waiting for a clock edge.
  - After deassertion with req=8'hA0, first grant goes to 7.
